// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory-stage access controller
package mem_pkg;

  // Access FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] ERR_DATA    = 16'hDEAD;
  localparam int          TIMEOUT_DEF = 15;
  localparam int          CNT_W       = 8;

endpackage

// File: rtl/access_timer.sv
// rtl/access_timer.sv - loadable up-counter flagging the last BUSY cycle before timeout
module access_timer #(
  parameter int CNT_W = 8,
  parameter int LIMIT = 15
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_inc,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  // Load takes priority over increment; reset clears the count
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Terminal count: the count will reach LIMIT on the coming edge
  assign o_tc = (r_count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/dff_16bit.sv
// rtl/dff_16bit.sv - 16-bit enabled register with synchronous active-high reset
module dff_16bit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [15:0] i_d,
  output logic [15:0] o_q
);

  logic [15:0] r_q;

  // Hold unless enabled; reset forces zero
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= 16'h0000;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-stage load/store controller with stall, bubble and timeout
module mem_access
  import mem_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EX_MemRead,
  input  logic              EX_MemWrite,
  input  logic              EX_RegWrite,
  input  logic [DATA_W-1:0] EX_ALUResult,
  input  logic [DATA_W-1:0] EX_StoreData,
  input  logic [REG_W-1:0]  EX_DstReg,
  output logic              MEM_RegWrite,
  output logic [DATA_W-1:0] MEM_WriteData,
  output logic [DATA_W-1:0] MEM_ReadData,
  output logic [REG_W-1:0]  MEM_DstReg,
  output logic              mem_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              mem_err
);

  state_t            r_state;
  state_t            w_next;
  logic              w_acc;
  logic              w_issue;
  logic              w_busy;
  logic              w_tc;
  logic              w_timeout;
  logic              w_cap_en;
  logic [DATA_W-1:0] w_cap_d;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_wr;
  logic              r_err;

  assign w_acc     = EX_MemRead | EX_MemWrite;
  assign w_issue   = (r_state == IDLE) && w_acc;
  assign w_busy    = (r_state == BUSY);
  // Valid beats the timeout when both land on the same edge
  assign w_timeout = w_busy && !mem_valid && w_tc;

  access_timer #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT)
  ) u_timer (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_issue),
    .i_load_val ('0),
    .i_inc      (w_busy),
    .o_tc       (w_tc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; DONE always retires since it never stalls EX/MEM
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_next = BUSY;
      BUSY:    if (mem_valid || w_tc) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Per-state outputs: stall, request strobe and capture control
  always_comb begin
    mem_stall = 1'b0;
    mem_en    = 1'b0;
    w_cap_en  = 1'b0;
    w_cap_d   = r_wr ? '0 : mem_rdata;
    case (r_state)
      IDLE: begin
        mem_stall = w_acc;
        mem_en    = w_acc;
      end
      BUSY: begin
        mem_stall = 1'b1;
        w_cap_en  = mem_valid || w_tc;
        if (w_timeout) w_cap_d = DATA_W'(ERR_DATA);
      end
      default: ;
    endcase
  end

  // Request fields latched at issue; sticky error on a timed-out access
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_issue) begin
        r_addr  <= EX_ALUResult;
        r_wdata <= EX_StoreData;
        r_wr    <= EX_MemWrite;
      end
      if (w_timeout) r_err <= 1'b1;
    end
  end

  dff_16bit u_capture (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (w_cap_en),
    .i_d   (w_cap_d),
    .o_q   (MEM_ReadData)
  );

  // The issue cycle shows the EX request directly; later cycles show the latched copy
  assign mem_addr      = w_issue ? EX_ALUResult : r_addr;
  assign mem_wdata     = w_issue ? EX_StoreData : r_wdata;
  assign mem_wr        = w_issue ? EX_MemWrite  : r_wr;
  assign mem_err       = r_err;
  assign MEM_RegWrite  = EX_RegWrite & ~mem_stall;
  assign MEM_WriteData = EX_ALUResult;
  assign MEM_DstReg    = EX_DstReg;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access with a latency-level reference model
module tb_mem_access;

  localparam int          TO      = 15;
  localparam logic [15:0] DEAD_V  = 16'hDEAD;

  logic        clk = 1'b0;
  logic        rst;
  logic        EX_MemRead, EX_MemWrite, EX_RegWrite;
  logic [15:0] EX_ALUResult, EX_StoreData;
  logic [3:0]  EX_DstReg;
  logic        MEM_RegWrite;
  logic [15:0] MEM_WriteData, MEM_ReadData;
  logic [3:0]  MEM_DstReg;
  logic        mem_stall, mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_valid, mem_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic        model_err;
  logic [15:0] model_rd;

  mem_access #(.DATA_W(16), .REG_W(4), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .EX_MemRead    (EX_MemRead),
    .EX_MemWrite   (EX_MemWrite),
    .EX_RegWrite   (EX_RegWrite),
    .EX_ALUResult  (EX_ALUResult),
    .EX_StoreData  (EX_StoreData),
    .EX_DstReg     (EX_DstReg),
    .MEM_RegWrite  (MEM_RegWrite),
    .MEM_WriteData (MEM_WriteData),
    .MEM_ReadData  (MEM_ReadData),
    .MEM_DstReg    (MEM_DstReg),
    .mem_stall     (mem_stall),
    .mem_en        (mem_en),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_valid     (mem_valid),
    .mem_err       (mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Non-memory operation: no stall, direct pass-through, capture and error untouched
  task automatic alu_op(input logic [15:0] val, input logic [3:0] dst, input logic rw,
                        input logic stray_valid);
    EX_MemRead = 1'b0; EX_MemWrite = 1'b0; EX_RegWrite = rw;
    EX_ALUResult = val; EX_StoreData = 16'($urandom); EX_DstReg = dst;
    mem_valid = stray_valid; mem_rdata = 16'($urandom);
    @(negedge clk);
    chk("alu_stall", mem_stall, 0);
    chk("alu_en", mem_en, 0);
    chk("alu_regwrite", MEM_RegWrite, rw);
    chk("alu_wdata", MEM_WriteData, val);
    chk("alu_dst", MEM_DstReg, dst);
    chk("alu_rdata_hold", MEM_ReadData, model_rd);
    chk("alu_err", mem_err, model_err);
    next_cycle();
    mem_valid = 1'b0;
  endtask

  // Memory access with response latency lat (0 or >TO means no response in time)
  task automatic do_access(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wd, input int lat, input logic [15:0] rdat,
                           input logic [3:0] dst, input logic rw, input logic early);
    logic        tmo;
    int          exp_stall;
    logic [15:0] exp_rd;
    int          stalls;
    tmo       = (lat < 1) || (lat > TO);
    exp_stall = tmo ? TO + 1 : lat + 1;
    exp_rd    = tmo ? DEAD_V : (wr ? 16'h0000 : rdat);
    EX_MemRead = rd; EX_MemWrite = wr; EX_RegWrite = rw;
    EX_ALUResult = addr; EX_StoreData = wd; EX_DstReg = dst;
    stalls = 0;
    for (int c = 0; c < TO + 6; c++) begin
      mem_valid = ((c == lat) && !tmo) || ((c == 0) && early);
      mem_rdata = (c == lat) ? rdat : 16'($urandom);
      @(negedge clk);
      if (!mem_stall) break;
      stalls++;
      if (c == 0) begin
        chk("issue_en", mem_en, 1);
        chk("issue_wr", mem_wr, wr);
        chk("issue_addr", mem_addr, addr);
        chk("issue_wdata", mem_wdata, wd);
      end else begin
        chk("busy_en", mem_en, 0);
        chk("busy_addr_hold", mem_addr, addr);
        chk("busy_wr_hold", mem_wr, wr);
      end
      chk("stall_bubble", MEM_RegWrite, 0);
      next_cycle();
    end
    if (tmo) model_err = 1'b1;
    model_rd = exp_rd;
    chk("stall_cycles", stalls, exp_stall);
    chk("done_rdata", MEM_ReadData, exp_rd);
    chk("done_regwrite", MEM_RegWrite, rw);
    chk("done_dst", MEM_DstReg, dst);
    chk("done_en", mem_en, 0);
    chk("done_err", mem_err, model_err);
    next_cycle();
    mem_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_rdata = 16'h0;
    EX_MemRead = 1'b0; EX_MemWrite = 1'b0; EX_RegWrite = 1'b0;
    EX_ALUResult = 16'h0; EX_StoreData = 16'h0; EX_DstReg = 4'h0;
    model_err = 1'b0; model_rd = 16'h0000;
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_stall", mem_stall, 0);
    chk("rst_en", mem_en, 0);
    chk("rst_rdata", MEM_ReadData, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wr", mem_wr, 0);
    next_cycle();

    // Load with latency 1
    do_access(1'b1, 1'b0, 16'h0040, 16'h0000, 1, 16'hBEEF, 4'd3, 1'b1, 1'b0);

    // Reset while BUSY, then a stale response
    EX_MemRead = 1'b1; EX_MemWrite = 1'b0; EX_RegWrite = 1'b1;
    EX_ALUResult = 16'h0040; EX_DstReg = 4'd5; mem_valid = 1'b0;
    @(negedge clk);
    chk("rb_issue_en", mem_en, 1);
    next_cycle();
    @(negedge clk);
    chk("rb_busy_stall", mem_stall, 1);
    next_cycle();
    rst = 1'b1; EX_MemRead = 1'b0; EX_RegWrite = 1'b0;
    next_cycle();
    rst = 1'b0; mem_valid = 1'b1; mem_rdata = 16'h5555;
    @(negedge clk);
    chk("rb_stall", mem_stall, 0);
    chk("rb_en", mem_en, 0);
    next_cycle();
    mem_valid = 1'b0;
    @(negedge clk);
    chk("rb_rdata", MEM_ReadData, 0);
    chk("rb_err", mem_err, 0);
    chk("rb_stall2", mem_stall, 0);
    model_rd = 16'h0000;
    next_cycle();

    // Store with latency 4, with an ignored issue-cycle pulse
    do_access(1'b0, 1'b1, 16'h0010, 16'h1234, 4, 16'hFFFF, 4'd1, 1'b0, 1'b1);

    // ALU pass-through
    alu_op(16'h0007, 4'd2, 1'b1, 1'b0);

    // Valid on the timeout edge
    do_access(1'b1, 1'b0, 16'h0080, 16'h0000, TO, 16'hA5A5, 4'd7, 1'b1, 1'b0);

    // Randomized mix, back-to-back
    for (int i = 0; i < 24; i++) begin
      int op;
      op = $urandom_range(0, 3);
      if (op == 0)
        alu_op(16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      else
        do_access(op == 1 || op == 3, op >= 2, 16'($urandom), 16'($urandom),
                  $urandom_range(1, TO), 16'($urandom), 4'($urandom), 1'($urandom),
                  1'($urandom));
    end

    // Timeout, then a late response that must be discarded
    do_access(1'b1, 1'b0, 16'h0100, 16'h0000, 0, 16'h0000, 4'd9, 1'b1, 1'b0);
    alu_op(16'h0003, 4'd4, 1'b1, 1'b1);
    do_access(1'b1, 1'b0, 16'h0200, 16'h0000, 2, 16'h4321, 4'd6, 1'b1, 1'b0);

    // Reset clears the sticky error
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("final_err_clear", mem_err, 0);
    chk("final_rdata_clear", MEM_ReadData, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
